// File: rtl/atm_pkg.sv
// Shared types and constants for the single-account ATM controller.
package atm_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LANG   = 3'd1,
        PINCHK = 3'd2,
        MENU   = 3'd3,
        WDRAW  = 3'd4,
        DEP    = 3'd5,
        BAL    = 3'd6,
        EXIT   = 3'd7
    } state_t;

    localparam logic [1:0] OP_WDRAW = 2'd0;
    localparam logic [1:0] OP_DEP   = 2'd1;
    localparam logic [1:0] OP_BAL   = 2'd2;
    localparam logic [1:0] OP_EXIT  = 2'd3;

    // Balance plus deposit, clamped at 255 so the account never wraps.
    function automatic logic [7:0] sat_add8(input logic [7:0] bal, input logic [4:0] amt);
        logic [8:0] sum;
        sum = {1'b0, bal} + {4'b0000, amt};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/main_module.sv
// Single-account ATM controller: card -> language -> PIN -> operation menu.
// The balance register survives sessions; only rst reloads it.
//
//  state  | meaning
//  IDLE   | waiting for a card
//  LANG   | waiting for language choice
//  PINCHK | comparing entered PIN, counting wrong attempts
//  MENU   | dispatching on Operation
//  WDRAW  | withdraw pending until amount fits or goMain
//  DEP    | adding deposit (saturating)
//  BAL    | reporting balance on FinalBalance
//  EXIT   | reporting balance, then back to IDLE
module main_module
    import atm_pkg::*;
#(
    parameter logic [7:0] INIT_BALANCE  = 8'd100,
    parameter logic [3:0] PIN_CODE      = 4'b1101,
    parameter int         MAX_PIN_TRIES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       IC,
    input  logic       LC,
    input  logic       Ex,
    input  logic [3:0] Pin,
    input  logic [1:0] Operation,
    input  logic [5:0] WithDraw_Amount,
    input  logic [4:0] Deposit_Amount,
    input  logic       goMain,
    output logic [7:0] FinalBalance,
    output logic [7:0] CB
);

    localparam int TRIES_W = $clog2(MAX_PIN_TRIES + 1);
    localparam logic [TRIES_W-1:0] TRIES_MAX = TRIES_W'(MAX_PIN_TRIES);

    state_t             state_q, state_d;
    logic [7:0]         balance_q, balance_d;
    logic [7:0]         final_q, final_d;
    logic [TRIES_W-1:0] tries_q, tries_d;

    logic [7:0]         wd_amt;
    logic [TRIES_W-1:0] tries_inc;

    assign wd_amt    = {2'b00, WithDraw_Amount};
    assign tries_inc = tries_q + 1'b1;

    // Registered state, balance, report and PIN-attempt counter with sync reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            balance_q <= INIT_BALANCE;
            final_q   <= 8'd0;
            tries_q   <= '0;
        end else begin
            state_q   <= state_d;
            balance_q <= balance_d;
            final_q   <= final_d;
            tries_q   <= tries_d;
        end
    end

    // Next-state and datapath updates; Ex overrides every state.
    always_comb begin
        state_d   = state_q;
        balance_d = balance_q;
        final_d   = final_q;
        tries_d   = tries_q;
        if (Ex) begin
            state_d = IDLE;
            tries_d = '0;
        end else begin
            unique case (state_q)
                IDLE:   if (IC) state_d = LANG;
                LANG:   if (LC) state_d = PINCHK;
                PINCHK: begin
                    if (Pin == PIN_CODE) begin
                        state_d = MENU;
                        tries_d = '0;
                    end else if (tries_inc >= TRIES_MAX) begin
                        state_d = IDLE;
                        tries_d = '0;
                    end else begin
                        tries_d = tries_inc;
                    end
                end
                MENU: begin
                    unique case (Operation)
                        OP_WDRAW: state_d = WDRAW;
                        OP_DEP:   state_d = DEP;
                        OP_BAL:   state_d = BAL;
                        OP_EXIT:  state_d = EXIT;
                    endcase
                end
                WDRAW: begin
                    if (goMain) begin
                        state_d = MENU;
                    end else if (wd_amt <= balance_q) begin
                        balance_d = balance_q - wd_amt;
                        final_d   = balance_q - wd_amt;
                        state_d   = MENU;
                    end
                end
                DEP: begin
                    balance_d = sat_add8(balance_q, Deposit_Amount);
                    final_d   = sat_add8(balance_q, Deposit_Amount);
                    state_d   = MENU;
                end
                BAL: begin
                    final_d = balance_q;
                    state_d = MENU;
                end
                EXIT: begin
                    final_d = balance_q;
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign FinalBalance = final_q;
    assign CB           = balance_q;

endmodule

// File: tb/tb_main_module.sv
// Scoreboard bench for the ATM controller: each step pushes the expected
// state/CB/FinalBalance, samples the DUT 1 time unit after the edge, and
// each test task compares its own queued expectations against samples.
module tb_main_module;
    import atm_pkg::*;

    typedef struct {
        state_t     st;
        logic [7:0] cb;
        logic [7:0] fb;
        string      name;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       IC, LC, Ex, goMain;
    logic [3:0] Pin;
    logic [1:0] Operation;
    logic [5:0] WithDraw_Amount;
    logic [4:0] Deposit_Amount;
    logic [7:0] FinalBalance, CB;

    int tests_run = 0;
    int tests_failed = 0;

    snap_t exp_q[$];
    snap_t obs_q[$];

    main_module dut (
        .clk             (clk),
        .rst             (rst),
        .IC              (IC),
        .LC              (LC),
        .Ex              (Ex),
        .Pin             (Pin),
        .Operation       (Operation),
        .WithDraw_Amount (WithDraw_Amount),
        .Deposit_Amount  (Deposit_Amount),
        .goMain          (goMain),
        .FinalBalance    (FinalBalance),
        .CB              (CB)
    );

    always #5 clk = ~clk;

    // Queue the expectation, clock once, queue what the DUT shows.
    task automatic step(input string name, input state_t st, input logic [7:0] cb, input logic [7:0] fb);
        snap_t e, o;
        e.st = st; e.cb = cb; e.fb = fb; e.name = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o.st = state_t'(dut.state_q); o.cb = CB; o.fb = FinalBalance; o.name = name;
        obs_q.push_back(o);
    endtask

    task automatic test_reset();
        snap_t e, o;
        rst = 1'b1;
        step("reset", IDLE, 8'd100, 8'd0);
        rst = 1'b0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o.st !== e.st || o.cb !== e.cb || o.fb !== e.fb) begin
                tests_failed++;
                $display("FAIL %s: got state=%s CB=%0d FB=%0d, want state=%s CB=%0d FB=%0d",
                         e.name, o.st.name(), o.cb, o.fb, e.st.name(), e.cb, e.fb);
            end
        end
    endtask

    task automatic test_balance();
        snap_t e, o;
        IC = 1'b1;
        step("card", LANG, 8'd100, 8'd0);
        LC = 1'b1;
        step("lang", PINCHK, 8'd100, 8'd0);
        Pin = 4'b1101;
        step("pin_ok", MENU, 8'd100, 8'd0);
        Operation = OP_BAL;
        step("menu_bal", BAL, 8'd100, 8'd0);
        step("bal_report", MENU, 8'd100, 8'd100);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o.st !== e.st || o.cb !== e.cb || o.fb !== e.fb) begin
                tests_failed++;
                $display("FAIL %s: got state=%s CB=%0d FB=%0d, want state=%s CB=%0d FB=%0d",
                         e.name, o.st.name(), o.cb, o.fb, e.st.name(), e.cb, e.fb);
            end
        end
    endtask

    task automatic test_withdraw();
        snap_t e, o;
        Operation = OP_WDRAW;
        WithDraw_Amount = 6'd40;
        step("wd_enter", WDRAW, 8'd100, 8'd100);
        step("wd_40", MENU, 8'd60, 8'd60);
        WithDraw_Amount = 6'd63;
        step("wd_reenter", WDRAW, 8'd60, 8'd60);
        step("wd_63_stay", WDRAW, 8'd60, 8'd60);
        step("wd_63_stay2", WDRAW, 8'd60, 8'd60);
        goMain = 1'b1;
        step("wd_gomain", MENU, 8'd60, 8'd60);
        goMain = 1'b0;
        WithDraw_Amount = 6'd0;
        step("wd0_enter", WDRAW, 8'd60, 8'd60);
        step("wd_0_noop", MENU, 8'd60, 8'd60);
        WithDraw_Amount = 6'd61;
        step("wd61_enter", WDRAW, 8'd60, 8'd60);
        step("wd_61_over", WDRAW, 8'd60, 8'd60);
        WithDraw_Amount = 6'd60;
        step("wd_60_exact", MENU, 8'd0, 8'd0);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o.st !== e.st || o.cb !== e.cb || o.fb !== e.fb) begin
                tests_failed++;
                $display("FAIL %s: got state=%s CB=%0d FB=%0d, want state=%s CB=%0d FB=%0d",
                         e.name, o.st.name(), o.cb, o.fb, e.st.name(), e.cb, e.fb);
            end
        end
    endtask

    task automatic test_deposit();
        snap_t e, o;
        int bal = 0;
        Operation = OP_DEP;
        Deposit_Amount = 5'd0;
        step("dep0_enter", DEP, 8'd0, 8'd0);
        step("dep_0_noop", MENU, 8'd0, 8'd0);
        Deposit_Amount = 5'd31;
        for (int i = 0; i < 8; i++) begin
            step("dep31_enter", DEP, 8'(bal), 8'(bal));
            bal = bal + 31;
            step("dep_31", MENU, 8'(bal), 8'(bal));
        end
        Deposit_Amount = 5'd2;
        step("dep2_enter", DEP, 8'd248, 8'd248);
        step("dep_2", MENU, 8'd250, 8'd250);
        Deposit_Amount = 5'd31;
        step("dep_sat_enter", DEP, 8'd250, 8'd250);
        step("dep_saturate", MENU, 8'd255, 8'd255);
        step("dep_sat_enter2", DEP, 8'd255, 8'd255);
        step("dep_saturate2", MENU, 8'd255, 8'd255);
        IC = 1'b0;
        Operation = OP_EXIT;
        step("exit_enter", EXIT, 8'd255, 8'd255);
        step("exit_idle", IDLE, 8'd255, 8'd255);
        step("idle_hold", IDLE, 8'd255, 8'd255);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o.st !== e.st || o.cb !== e.cb || o.fb !== e.fb) begin
                tests_failed++;
                $display("FAIL %s: got state=%s CB=%0d FB=%0d, want state=%s CB=%0d FB=%0d",
                         e.name, o.st.name(), o.cb, o.fb, e.st.name(), e.cb, e.fb);
            end
        end
    endtask

    task automatic test_pin_and_exit();
        snap_t e, o;
        IC = 1'b1;
        LC = 1'b1;
        Operation = OP_BAL;
        step("s2_card", LANG, 8'd255, 8'd255);
        step("s2_lang", PINCHK, 8'd255, 8'd255);
        Pin = 4'b0000;
        step("bad_pin1", PINCHK, 8'd255, 8'd255);
        step("bad_pin2", PINCHK, 8'd255, 8'd255);
        Pin = 4'b1101;
        step("pin_after_2bad", MENU, 8'd255, 8'd255);
        Ex = 1'b1;
        step("ex_in_menu", IDLE, 8'd255, 8'd255);
        Ex = 1'b0;
        step("s3_card", LANG, 8'd255, 8'd255);
        step("s3_lang", PINCHK, 8'd255, 8'd255);
        Pin = 4'b0000;
        step("s3_bad1", PINCHK, 8'd255, 8'd255);
        step("s3_bad2", PINCHK, 8'd255, 8'd255);
        step("pin_abort", IDLE, 8'd255, 8'd255);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o.st !== e.st || o.cb !== e.cb || o.fb !== e.fb) begin
                tests_failed++;
                $display("FAIL %s: got state=%s CB=%0d FB=%0d, want state=%s CB=%0d FB=%0d",
                         e.name, o.st.name(), o.cb, o.fb, e.st.name(), e.cb, e.fb);
            end
        end
    endtask

    task automatic test_reset_mid_deposit();
        snap_t e, o;
        step("s4_card", LANG, 8'd255, 8'd255);
        step("s4_lang", PINCHK, 8'd255, 8'd255);
        Pin = 4'b1101;
        step("s4_pin", MENU, 8'd255, 8'd255);
        Operation = OP_DEP;
        Deposit_Amount = 5'd10;
        step("s4_dep_enter", DEP, 8'd255, 8'd255);
        rst = 1'b1;
        step("rst_in_dep", IDLE, 8'd100, 8'd0);
        rst = 1'b0;
        IC = 1'b0;
        step("post_rst_idle", IDLE, 8'd100, 8'd0);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o.st !== e.st || o.cb !== e.cb || o.fb !== e.fb) begin
                tests_failed++;
                $display("FAIL %s: got state=%s CB=%0d FB=%0d, want state=%s CB=%0d FB=%0d",
                         e.name, o.st.name(), o.cb, o.fb, e.st.name(), e.cb, e.fb);
            end
        end
    endtask

    initial begin
        rst = 1'b0; IC = 1'b0; LC = 1'b0; Ex = 1'b0; goMain = 1'b0;
        Pin = 4'b0000; Operation = 2'd0; WithDraw_Amount = 6'd0; Deposit_Amount = 5'd0;
        #2;
        test_reset();
        test_balance();
        test_withdraw();
        test_deposit();
        test_pin_and_exit();
        test_reset_mid_deposit();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
